tx_scheduler: RTL

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_sched_pkg.sv | 27 ++
 rtl/tx_scheduler_rr_arb4.sv | 27 ++
 rtl/tx_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the four-source message transmit scheduler.
package tx_sched_pkg;

   localparam int         NUM_SRC           = 4;
   localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h00;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      FETCH,
      SEND,
      WAIT,
      NEXT,
      DONE
   } state_t;

   // Index of the set bit in a one-hot source vector (0 when none is set).
   function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tx_scheduler_rr_arb4.sv
// Combinational round-robin picker: first pending source after last_grant, wrapping mod 4.
module rr_arb4
   import tx_sched_pkg::*;
(
   input  logic [NUM_SRC-1:0] pending_i,
   input  logic [1:0]         last_grant_i,
   output logic [NUM_SRC-1:0] gnt_o
);

   logic [1:0] idx;
   logic       found;

   // Offset NUM_SRC wraps back onto last_grant itself, so it is considered last.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = last_grant_i + 2'(k);
         if (!found && pending_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_scheduler.sv
// Queues per-source message requests and streams each granted ROM message byte by byte
// to a serial transmitter using a start/busy handshake.
module tx_scheduler
   import tx_sched_pkg::*;
#(
   parameter int         MSG_LEN   = 16,
   parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEFAULT
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [7:0] rom_data0,
   input  logic [7:0] rom_data1,
   input  logic [7:0] rom_data2,
   input  logic [7:0] rom_data3,
   output logic [3:0] rom_addr,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic [3:0] grant,
   output logic       done
);

   localparam logic [3:0] LAST_ADDR = 4'(MSG_LEN - 1);

   state_t             state_q;
   logic [NUM_SRC-1:0] req_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] pending_d;
   logic [1:0]         last_grant_q;
   logic [3:0]         rom_addr_q;
   logic [3:0]         rom_addr_d;
   logic [7:0]         tx_data_q;
   logic               tx_start_q;
   logic [NUM_SRC-1:0] grant_q;
   logic               done_q;

   logic [NUM_SRC-1:0] req_rise;
   logic [NUM_SRC-1:0] pend_clr;
   logic [NUM_SRC-1:0] arb_gnt;
   logic [7:0]         rom_bus [NUM_SRC];
   logic [7:0]         rom_byte;

   assign req_rise   = req & ~req_q;
   assign pend_clr   = (state_q == DONE) ? grant_q : '0;
   assign rom_addr_d = rom_addr_q + 4'd1;

   // A fresh edge wins over the DONE clear so a re-request is never lost.
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
         assign pending_d[gi] = req_rise[gi] | (pending_q[gi] & ~pend_clr[gi]);
      end
   endgenerate

   assign rom_bus[0] = rom_data0;
   assign rom_bus[1] = rom_data1;
   assign rom_bus[2] = rom_data2;
   assign rom_bus[3] = rom_data3;

   always_comb begin
      rom_byte = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q[i]) rom_byte = rom_byte | rom_bus[i];
      end
   end

   rr_arb4 u_arb (
      .pending_i   (pending_q),
      .last_grant_i(last_grant_q),
      .gnt_o       (arb_gnt)
   );

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_q        <= '0;
         pending_q    <= '0;
         last_grant_q <= 2'd3;
         rom_addr_q   <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         grant_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         req_q     <= req;
         pending_q <= pending_d;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|pending_q) state_q <= ARB;
            end
            ARB: begin
               grant_q      <= arb_gnt;
               rom_addr_q   <= '0;
               last_grant_q <= onehot_to_idx(arb_gnt);
               state_q      <= FETCH;
            end
            FETCH: begin
               tx_data_q <= rom_byte;
               if (rom_byte == TERM_BYTE) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  tx_start_q <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (tx_busy) begin
                  tx_start_q <= 1'b0;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (!tx_busy) state_q <= NEXT;
            end
            NEXT: begin
               if (rom_addr_q == LAST_ADDR) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  rom_addr_q <= rom_addr_d;
                  state_q    <= FETCH;
               end
            end
            DONE: begin
               grant_q <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_addr = rom_addr_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign grant    = grant_q;
   assign done     = done_q;

endmodule
